// File: rtl/audio_frame_sequencer.sv
// Audio frame sequencer: gates the upstream sample source for one utterance,
// slices the sample stream into FRAME_LEN-sample frames with first/last
// markers, zero-pads a short final frame, and signals completion.
module audio_frame_sequencer #(
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = 256,
  parameter int MAX_FRAMES = 64,
  localparam int IDX_W     = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1,
  localparam int CNT_W     = $clog2(FRAME_LEN),
  localparam int DONE_W    = $clog2(MAX_FRAMES) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              src_enable,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  output logic [IDX_W-1:0]  frame_idx,
  output logic [DONE_W-1:0] frames_done,
  output logic              busy,
  output logic              done,
  output logic              truncated
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_PAD     = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   sample_cnt;
  logic [DONE_W-1:0]  frames_next;
  logic               cnt_last;
  logic               take;
  logic               emit;
  logic               frame_end;
  logic               limit_hit;
  logic               capture_start;

  // Per-cycle decode of sample acceptance, frame boundaries and the frame limit.
  always_comb begin
    cnt_last      = (sample_cnt == CNT_W'(FRAME_LEN - 1));
    // A sample is accepted only while capturing; abort drops it.
    take          = (state == S_CAPTURE) && in_valid && !abort;
    // Padding produces one zero sample every cycle in PAD.
    emit          = take || ((state == S_PAD) && !abort);
    frame_end     = emit && cnt_last;
    frames_next   = frames_done + DONE_W'(1);
    limit_hit     = (frames_next == DONE_W'(MAX_FRAMES));
    capture_start = (state == S_IDLE) && start && !abort;
  end

  // Next-state selection; abort overrides everything else.
  always_comb begin
    // NOTE: assign a default before any branch so that no path leaves
    // state_next unassigned; otherwise synthesis infers a latch.
    state_next = state;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state_next = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (take) begin
            if (frame_end && limit_hit) begin
              state_next = S_DONE;
            end else if (in_last) begin
              state_next = cnt_last ? S_DONE : S_PAD;
            end
          end
        end
        S_PAD: begin
          if (cnt_last) state_next = S_DONE;
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Output sample register: one-cycle strobes, data held between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= emit;
      out_first <= emit && (sample_cnt == '0);
      out_last  <= frame_end;
      if (emit) out_data <= take ? in_data : '0;
    end
  end

  // Sample/frame counters and the truncation flag, cleared on start and abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_cnt  <= '0;
      frame_idx   <= '0;
      frames_done <= '0;
      truncated   <= 1'b0;
    end else if (abort || capture_start) begin
      sample_cnt  <= '0;
      frame_idx   <= '0;
      frames_done <= '0;
      truncated   <= 1'b0;
    end else if (emit) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      if (cnt_last) begin
        frame_idx   <= frame_idx + IDX_W'(1);
        frames_done <= frames_next;
        if (limit_hit) truncated <= 1'b1;
      end
    end
  end

  assign src_enable = (state == S_CAPTURE);
  assign busy       = (state == S_CAPTURE) || (state == S_PAD);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Self-checking bench for audio_frame_sequencer: two instances (default
// frame limit and a two-frame limit) share one stimulus stream and are
// compared every cycle against a count-based reference model, plus a
// vector table and directed checks for the multi-cycle corner cases.
module tb_audio_frame_sequencer;

  localparam int FL     = 256;
  localparam int DW     = 16;
  localparam int MAX_A  = 64;
  localparam int MAX_B  = 2;
  localparam int IDX_A  = 6;
  localparam int DONE_A = 7;
  localparam int IDX_B  = 1;
  localparam int DONE_B = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_last;

  logic          src_enable_a, out_valid_a, out_first_a, out_last_a;
  logic          busy_a, done_a, truncated_a;
  logic [DW-1:0] out_data_a;
  logic [IDX_A-1:0]  frame_idx_a;
  logic [DONE_A-1:0] frames_done_a;

  logic          src_enable_b, out_valid_b, out_first_b, out_last_b;
  logic          busy_b, done_b, truncated_b;
  logic [DW-1:0] out_data_b;
  logic [IDX_B-1:0]  frame_idx_b;
  logic [DONE_B-1:0] frames_done_b;

  audio_frame_sequencer #(.DATA_W(DW), .FRAME_LEN(FL), .MAX_FRAMES(MAX_A)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .src_enable(src_enable_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_first(out_first_a), .out_last(out_last_a), .frame_idx(frame_idx_a),
    .frames_done(frames_done_a), .busy(busy_a), .done(done_a), .truncated(truncated_a)
  );

  audio_frame_sequencer #(.DATA_W(DW), .FRAME_LEN(FL), .MAX_FRAMES(MAX_B)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .src_enable(src_enable_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_first(out_first_b), .out_last(out_last_b), .frame_idx(frame_idx_b),
    .frames_done(frames_done_b), .busy(busy_b), .done(done_b), .truncated(truncated_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] vec_a, vec_b;
  assign vec_a = 64'({src_enable_a, busy_a, done_a, truncated_a, out_valid_a,
                      out_first_a, out_last_a, out_data_a, frame_idx_a, frames_done_a});
  assign vec_b = 64'({src_enable_b, busy_b, done_b, truncated_b, out_valid_b,
                      out_first_b, out_last_b, out_data_b, frame_idx_b, frames_done_b});

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: everything is derived from the number of samples
  // emitted so far in the utterance and the padding still owed.
  // ---------------------------------------------------------------------
  localparam logic [1:0] M_IDLE = 2'd0, M_CAP = 2'd1, M_PAD = 2'd2, M_DONE = 2'd3;

  typedef struct packed {
    logic [1:0]  phase;
    int          emitted;
    int          pad_left;
    logic        trunc;
    logic        valid;
    logic        first;
    logic        last;
    logic [15:0] data;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '0;
    return m;
  endfunction

  function automatic mdl_t model_step(mdl_t m, int max_frames, logic st, logic ab,
                                      logic iv, logic il, logic [15:0] d);
    mdl_t n;
    n = m;
    n.valid = 1'b0;
    n.first = 1'b0;
    n.last  = 1'b0;
    if (ab) begin
      n.phase = M_IDLE; n.emitted = 0; n.pad_left = 0; n.trunc = 1'b0;
    end else begin
      case (m.phase)
        M_IDLE: if (st) begin
          n.phase = M_CAP; n.emitted = 0; n.trunc = 1'b0;
        end
        M_CAP: if (iv) begin
          n.valid   = 1'b1;
          n.data    = d;
          n.first   = ((m.emitted % FL) == 0);
          n.emitted = m.emitted + 1;
          n.last    = ((n.emitted % FL) == 0);
          if (n.last && (n.emitted / FL) == max_frames) begin
            n.trunc = 1'b1; n.phase = M_DONE;
          end else if (il) begin
            if (n.last) n.phase = M_DONE;
            else begin
              n.pad_left = FL - (n.emitted % FL);
              n.phase    = M_PAD;
            end
          end
        end
        M_PAD: begin
          n.valid    = 1'b1;
          n.data     = '0;
          n.first    = ((m.emitted % FL) == 0);
          n.emitted  = m.emitted + 1;
          n.pad_left = m.pad_left - 1;
          n.last     = (n.pad_left == 0);
          if (n.pad_left == 0) begin
            n.phase = M_DONE;
            if ((n.emitted / FL) == max_frames) n.trunc = 1'b1;
          end
        end
        default: n.phase = M_IDLE;
      endcase
    end
    return n;
  endfunction

  function automatic logic [63:0] model_vec(mdl_t m, int idx_w, int done_w);
    logic [63:0] v;
    int frames;
    frames = m.emitted / FL;
    v = {57'd0, (m.phase == M_CAP), (m.phase == M_CAP || m.phase == M_PAD),
         (m.phase == M_DONE), m.trunc, m.valid, m.first, m.last};
    v = (v << 16) | 64'(m.data);
    v = (v << idx_w) | 64'(frames % (1 << idx_w));
    v = (v << done_w) | 64'(frames);
    return v;
  endfunction

  typedef struct packed {
    logic        first;
    logic        last;
    logic [15:0] data;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];
  int   n_done_a = 0;
  int   n_done_b = 0;

  task automatic set_in(input logic st, input logic ab, input logic iv,
                        input logic il, input logic [15:0] d);
    start    = st;
    abort    = ab;
    in_valid = iv;
    in_last  = il;
    in_data  = d;
  endtask

  // One clock: advance both models with the inputs seen at the edge, then
  // compare every output of both instances a little after the edge.
  task automatic cycle();
    @(posedge clk);
    ma = model_step(ma, MAX_A, start, abort, in_valid, in_last, in_data);
    mb = model_step(mb, MAX_B, start, abort, in_valid, in_last, in_data);
    #1;
    check("cycle_a", vec_a, model_vec(ma, IDX_A, DONE_A));
    check("cycle_b", vec_b, model_vec(mb, IDX_B, DONE_B));
    if (out_valid_a) qa.push_back(rec_t'{out_first_a, out_last_a, out_data_a});
    if (out_valid_b) qb.push_back(rec_t'{out_first_b, out_last_b, out_data_b});
    n_done_a += int'(done_a);
    n_done_b += int'(done_b);
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    repeat (n) cycle();
  endtask

  task automatic clear_logs();
    qa.delete();
    qb.delete();
    n_done_a = 0;
    n_done_b = 0;
  endtask

  typedef struct {
    logic        st, ab, iv, il;
    logic [15:0] d;
    logic [5:0]  exp_ctl;   // src_enable, busy, done, out_valid, out_first, out_last
    logic [15:0] exp_data;
    logic [6:0]  exp_frames;
  } vec_t;

  vec_t tbl[9];

  task automatic random_runs();
    int   len;
    int   offered;
    logic iv, il, ab, st;
    for (int run = 0; run < 5; run++) begin
      len     = $urandom_range(1, 700);
      offered = 0;
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      cycle();
      for (int c = 0; c < 1000; c++) begin
        iv = ($urandom_range(0, 3) != 0);
        il = iv && (offered == len - 1);
        ab = ($urandom_range(0, 599) == 0);
        st = ($urandom_range(0, 39) == 0);
        set_in(st, ab, iv, il, 16'($urandom));
        if (iv) offered++;
        cycle();
      end
      set_in(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
      cycle();
    end
  endtask

  int zeros;
  int firsts;
  int lasts;

  initial begin
    ma = mdl_reset();
    mb = mdl_reset();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    reset = 1'b1;
    #3;
    check("reset_state_a", vec_a, 64'd0);
    check("reset_state_b", vec_b, 64'd0);
    #19;
    reset = 1'b0;

    // ---- Vector table: ignored inputs, start+abort, start during capture ----
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0011, 6'b000000, 16'h0000, 7'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 6'b000000, 16'h0000, 7'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b000000, 16'h0000, 7'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b110000, 16'h0000, 7'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 6'b110110, 16'h1234, 7'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h2222, 6'b110100, 16'h2222, 7'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h3333, 6'b110100, 16'h3333, 7'd0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h4444, 6'b000000, 16'h3333, 7'd0};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 6'b000000, 16'h3333, 7'd0};
    for (int i = 0; i < 9; i++) begin
      set_in(tbl[i].st, tbl[i].ab, tbl[i].iv, tbl[i].il, tbl[i].d);
      cycle();
      check($sformatf("table_%0d", i),
            64'({src_enable_a, busy_a, done_a, out_valid_a, out_first_a, out_last_a,
                 out_data_a, frames_done_a}),
            64'({tbl[i].exp_ctl, tbl[i].exp_data, tbl[i].exp_frames}));
    end

    // ---- Full stream: 512 samples, in_last on the 512th ----
    clear_logs();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cycle();
    for (int i = 0; i < 512; i++) begin
      set_in(1'b0, 1'b0, 1'b1, (i == 511), 16'(i));
      cycle();
    end
    idle(3);
    check("full_count_a", 64'(qa.size()), 64'd512);
    check("full_first_0", 64'(qa[0].first), 64'd1);
    check("full_first_256", 64'(qa[256].first), 64'd1);
    check("full_last_255", 64'(qa[255].last), 64'd1);
    check("full_last_511", 64'(qa[511].last), 64'd1);
    check("full_data_511", 64'(qa[511].data), 64'd511);
    check("full_frames_a", 64'(frames_done_a), 64'd2);
    check("full_trunc_a", 64'(truncated_a), 64'd0);
    check("full_done_a", 64'(n_done_a), 64'd1);
    check("full_last_and_limit_trunc_b", 64'(truncated_b), 64'd1);
    check("full_done_b", 64'(n_done_b), 64'd1);

    // ---- Short final frame: 300 samples, then 212 zeros of padding ----
    clear_logs();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cycle();
    for (int i = 0; i < 300; i++) begin
      set_in(1'b0, 1'b0, 1'b1, (i == 299), 16'(i + 1));
      cycle();
      if (i == 299) check("short_src_low_after_last", 64'(src_enable_a), 64'd0);
    end
    for (int i = 0; i < 215; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF);
      cycle();
    end
    idle(2);
    zeros = 0; firsts = 0; lasts = 0;
    foreach (qa[k]) begin
      if (k >= 300 && qa[k].data == 16'd0) zeros++;
      if (qa[k].first) firsts++;
      if (qa[k].last) lasts++;
    end
    check("short_count_a", 64'(qa.size()), 64'd512);
    check("short_data_299", 64'(qa[299].data), 64'd300);
    check("short_pad_zeros", 64'(zeros), 64'd212);
    check("short_firsts", 64'(firsts), 64'd2);
    check("short_lasts", 64'(lasts), 64'd2);
    check("short_last_511", 64'(qa[511].last), 64'd1);
    check("short_frames_a", 64'(frames_done_a), 64'd2);
    check("short_trunc_a", 64'(truncated_a), 64'd0);
    check("short_done_a", 64'(n_done_a), 64'd1);

    // ---- Frame limit on instance B: 600 samples, no in_last ----
    clear_logs();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cycle();
    for (int i = 0; i < 600; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'(i));
      cycle();
      if (i == 511) begin
        check("limit_src_low_b", 64'(src_enable_b), 64'd0);
        check("limit_src_high_a", 64'(src_enable_a), 64'd1);
      end
    end
    idle(2);
    check("limit_count_b", 64'(qb.size()), 64'd512);
    check("limit_trunc_b", 64'(truncated_b), 64'd1);
    check("limit_done_b", 64'(n_done_b), 64'd1);
    check("limit_frames_b", 64'(frames_done_b), 64'd2);
    check("limit_count_a", 64'(qa.size()), 64'd600);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    cycle();
    check("abort_clears_frames_a", 64'(frames_done_a), 64'd0);
    check("abort_clears_trunc_b", 64'(truncated_b), 64'd0);

    // ---- Abort at sample 100, then restart ----
    clear_logs();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cycle();
    for (int i = 0; i < 100; i++) begin
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'(i));
      cycle();
    end
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 16'd100);
    cycle();
    check("abort_busy_a", 64'(busy_a), 64'd0);
    check("abort_drop_sample_a", 64'(out_valid_a), 64'd0);
    check("abort_src_a", 64'(src_enable_a), 64'd0);
    idle(3);
    check("abort_no_done_a", 64'(n_done_a), 64'd0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cycle();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0055);
    cycle();
    check("restart_first_a", 64'(out_first_a), 64'd1);
    check("restart_idx_a", 64'(frame_idx_a), 64'd0);
    check("restart_data_a", 64'(out_data_a), 64'h55);
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    cycle();

    // ---- Asynchronous reset in the middle of padding ----
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    cycle();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 1'b0, 1'b1, (i == 9), 16'(i + 7));
      cycle();
    end
    idle(5);
    check("pad_busy_before_reset_a", 64'(busy_a), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_pad_a", vec_a, 64'd0);
    check("reset_mid_pad_b", vec_b, 64'd0);
    ma = mdl_reset();
    mb = mdl_reset();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    idle(1);
    check("post_reset_src_a", 64'(src_enable_a), 64'd0);
    check("post_reset_busy_a", 64'(busy_a), 64'd0);

    // ---- Randomized utterances against the model ----
    random_runs();
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_frame_sequencer.md
Name: audio_frame_sequencer

Overview:
- Controls one utterance capture from the AXI-to-simple sample converter and slices the sample stream into fixed-length frames for the feature-extraction stage (windowing/FFT/MFCC).
- Gates the upstream source with src_enable, counts samples, and marks the first and last sample of each frame.
- Zero-pads a short final frame and stops capture on end-of-stream, on the frame limit, or on abort.
- Reports completion to the top-level recognition controller.

Parameters:
- DATA_W, 16, sample width.
- FRAME_LEN, 256, samples per frame; power of two, ≥4.
- MAX_FRAMES, 64, maximum frames per utterance; ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins capture. Honoured only in IDLE.
- abort  in  1  level; cancels capture from any state.
- in_data  in  DATA_W  sample from the simple interface.
- in_valid  in  1  sample strobe, one cycle per sample.
- in_last  in  1  end-of-stream marker, qualified by in_valid.
- src_enable  out  1  permits the upstream converter/source to deliver samples.
- out_data  out  DATA_W  framed sample.
- out_valid  out  1  framed sample strobe.
- out_first  out  1  first sample of a frame, qualified by out_valid.
- out_last  out  1  last sample of a frame, qualified by out_valid.
- frame_idx  out  $clog2(MAX_FRAMES)  index of the frame currently being emitted.
- frames_done  out  $clog2(MAX_FRAMES)+1  completed frames in this utterance.
- busy  out  1  high in CAPTURE and PAD.
- done  out  1  one-cycle pulse at the end of a capture.
- truncated  out  1  capture ended by the MAX_FRAMES limit; held until the next start.

Behaviour:
- Reset values: every output 0; state IDLE; internal counters 0.
- States:
  - IDLE: src_enable=0. start → CAPTURE on the next edge. On entry to CAPTURE: clear sample_cnt, frame_idx, frames_done, truncated.
  - CAPTURE: src_enable=1, busy=1.
  - PAD: src_enable=0, busy=1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- CAPTURE, per in_valid:
  - Register the sample to out_data with out_valid=1; latency exactly 1 cycle.
  - out_first = (sample_cnt==0); out_last = (sample_cnt==FRAME_LEN-1).
  - sample_cnt increments and wraps to 0 after FRAME_LEN-1.
  - On the out_last sample: frame_idx increments and frames_done increments in the same cycle.
- in_last inside CAPTURE:
  - At sample_cnt==FRAME_LEN-1 → DONE, no padding.
  - Otherwise → PAD.
- PAD:
  - Emits out_data=0, out_valid=1 every cycle; sample_cnt keeps advancing.
  - The out_last sample completes the frame (frames_done increments) → DONE.
  - in_valid is ignored.
- Frame limit: the frame completing with frames_done reaching MAX_FRAMES → DONE, truncated=1. src_enable deasserts in the cycle after that last sample.
- Simultaneous in_last and frame limit: goes to DONE with truncated=1.
- in_valid while src_enable=0 (IDLE, PAD, DONE) is dropped; no output is produced.
- start outside IDLE is ignored.
- abort, highest priority, from any state:
  - Next edge → IDLE; out_valid/out_first/out_last/busy = 0; no done pulse.
  - Counters clear; truncated clears.
  - A sample arriving in the abort cycle is dropped.
  - abort and start in the same cycle → stay IDLE.
- out_valid, out_first and out_last are single-cycle; out_data holds its value between strobes.
- Asynchronous reset mid-capture → IDLE immediately; all outputs as at reset.

Test Plan:
- Full stream: start, 512 samples (value = index), in_last on sample 511, FRAME_LEN=256 → 2 frames. out_first on samples 0 and 256, out_last on 255 and 511. frames_done=2, done pulse, truncated=0, no padding.
- Short final frame: 300 samples, in_last on sample 299 → PAD emits 212 zeros. out_last on the 512th output. frames_done=2, src_enable low from the cycle after sample 299.
- Frame limit: MAX_FRAMES=2, 600 samples, no in_last → exactly 512 outputs. truncated=1, done pulse; src_enable low after sample 511; samples 512+ dropped.
- Abort: abort at sample 100 → next cycle IDLE, busy=0, no done. A new start then yields out_first on the first sample, frame_idx=0.
- Ignored inputs: start during CAPTURE leaves counters unchanged. in_valid in IDLE produces no out_valid. start+abort in the same cycle stays IDLE.
- Reset mid-PAD: assert reset → all outputs 0 asynchronously. After release, state is IDLE with src_enable=0.
